// File: rtl/tail_light_if.sv
// Switch-side / lamp-side bundle for the tail-light sequencer.
//   master : drives left/right/hazard/brake, observes tail_lights/busy
//   slave  : the sequencer itself
// tail_lights is 2*LAMPS wide: left half [2*LAMPS-1:LAMPS], right half [LAMPS-1:0].
interface tail_light_if #(
    parameter int LAMPS = 3
);
    logic                 left;
    logic                 right;
    logic                 hazard;
    logic                 brake;
    logic [2*LAMPS-1:0]   tail_lights;
    logic                 busy;

    modport master (output left, right, hazard, brake, input tail_lights, busy);
    modport slave  (input left, right, hazard, brake, output tail_lights, busy);
endinterface

// File: rtl/tail_light_sequencer.sv
// Rear-lamp sequencer: outward turn sweeps, hazard flash, brake overlay,
// per-step dwell of TICK_DIV cycles.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - tail_light_if slave: left/right/hazard/brake in, tail_lights/busy out
module tail_light_sequencer #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    tail_light_if.slave     bus
);
    localparam int SW = $clog2(LAMPS + 1);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);
    localparam logic [SW-1:0] STEP_ONE = SW'(1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

    state_t               r_state, w_state_nx;
    logic [SW-1:0]        r_step,  w_step_nx;
    logic [DW-1:0]        r_div,   w_div_nx;
    logic [2*LAMPS-1:0]   r_lamps, w_lamps_nx;
    logic                 r_busy,  w_busy_nx;
    logic                 w_tick;
    logic                 w_adv;

    assign w_tick = (r_div == DIV_MAX);

    // State register; divider preset so the first request after reset is taken at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_div   <= DIV_MAX;
            r_lamps <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_div   <= w_div_nx;
            r_lamps <= w_lamps_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // Next-state / step / divider
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_adv      = 1'b0;
        unique case (r_state)
            IDLE: if (w_tick) begin
                if (bus.hazard || (bus.left && bus.right)) begin
                    w_state_nx = HAZ;
                end else if (bus.left) begin
                    w_state_nx = LEFT;
                    w_step_nx  = STEP_ONE;
                end else if (bus.right) begin
                    w_state_nx = RIGHT;
                    w_step_nx  = STEP_ONE;
                end
            end
            LEFT, RIGHT: begin
                // hazard aborts immediately, even on the sequence's final tick
                if (bus.hazard) begin
                    w_state_nx = HAZ;
                    w_step_nx  = '0;
                end else if (w_tick) begin
                    if (r_step < STEP_MAX) begin
                        w_step_nx = r_step + STEP_ONE;
                        w_adv     = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                        w_step_nx  = '0;
                    end
                end
            end
            HAZ: if (w_tick) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase

        if (w_state_nx != r_state || w_adv)
            w_div_nx = '0;
        else if (!w_tick)
            w_div_nx = r_div + DW'(1);
        else
            w_div_nx = r_div;
    end

    // Outputs from next-state values so they move on the same edge as the state
    always_comb begin
        w_lamps_nx = '0;
        for (int i = 0; i < LAMPS; i++) begin
            if (w_state_nx == LEFT)
                w_lamps_nx[LAMPS + i]     = (i < int'(w_step_nx));
            if (w_state_nx == RIGHT)
                w_lamps_nx[LAMPS - 1 - i] = (i < int'(w_step_nx));
        end
        if (w_state_nx == HAZ)
            w_lamps_nx = '1;
        if (bus.brake) begin
            unique case (w_state_nx)
                IDLE:    w_lamps_nx = '1;
                LEFT:    w_lamps_nx[LAMPS-1:0]       = '1;
                RIGHT:   w_lamps_nx[2*LAMPS-1:LAMPS] = '1;
                default: ;
            endcase
        end
        w_busy_nx = (w_state_nx != IDLE);
    end

    assign bus.tail_lights = r_lamps;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: four configurations run side by side against
// a mode/age reference model, plus directed hold-left and async-reset checks.
module tb_tail_light_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tail_light_if #(.LAMPS(3)) if0 ();
    tail_light_if #(.LAMPS(3)) if1 ();
    tail_light_if #(.LAMPS(4)) if2 ();
    tail_light_if #(.LAMPS(1)) if3 ();

    tail_light_sequencer #(.LAMPS(3), .TICK_DIV(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    tail_light_sequencer #(.LAMPS(3), .TICK_DIV(4)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    tail_light_sequencer #(.LAMPS(4), .TICK_DIV(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    tail_light_sequencer #(.LAMPS(1), .TICK_DIV(3)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    logic [15:0] got_tl [4];
    logic        got_bz [4];
    assign got_tl[0] = 16'(if0.tail_lights);  assign got_bz[0] = if0.busy;
    assign got_tl[1] = 16'(if1.tail_lights);  assign got_bz[1] = if1.busy;
    assign got_tl[2] = 16'(if2.tail_lights);  assign got_bz[2] = if2.busy;
    assign got_tl[3] = 16'(if3.tail_lights);  assign got_bz[3] = if3.busy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=left 2=right 3=hazard; age = edges since mode entry
    int          cfg_l [4] = '{3, 3, 4, 1};
    int          cfg_t [4] = '{1, 4, 2, 3};
    int          md  [4];
    int          age [4];
    logic [15:0] ex_tl [4];
    logic        ex_bz [4];

    function automatic void mdl_reset(int k);
        md[k]    = 0;
        age[k]   = cfg_t[k] - 1;   // idle long enough: next request accepted at once
        ex_tl[k] = '0;
        ex_bz[k] = 1'b0;
    endfunction

    function automatic void mdl_step(int k, bit l, bit r, bit h, bit b);
        int L = cfg_l[k];
        int T = cfg_t[k];
        int n = md[k];
        int half, cnt, v;
        case (md[k])
            0: if (age[k] >= T - 1) begin
                if (h || (l && r)) n = 3;
                else if (l)        n = 1;
                else if (r)        n = 2;
            end
            1, 2: begin
                if (h)                          n = 3;
                else if (age[k] == L * T - 1)   n = 0;
            end
            default: if (age[k] >= T - 1) n = 0;
        endcase
        if (n != md[k]) age[k] = 0; else age[k]++;
        md[k] = n;
        half = (1 << L) - 1;
        cnt  = age[k] / T + 1;
        case (n)
            1:       v = ((1 << cnt) - 1) << L;
            2:       v = ((1 << cnt) - 1) << (L - cnt);
            3:       v = (half << L) | half;
            default: v = 0;
        endcase
        if (b) begin
            if (n == 0) v = (half << L) | half;
            if (n == 1) v = v | half;
            if (n == 2) v = v | (half << L);
        end
        ex_tl[k] = 16'(v);
        ex_bz[k] = (n != 0);
    endfunction

    task automatic apply(int k, bit l, bit r, bit h, bit b);
        case (k)
            0: begin if0.left = l; if0.right = r; if0.hazard = h; if0.brake = b; end
            1: begin if1.left = l; if1.right = r; if1.hazard = h; if1.brake = b; end
            2: begin if2.left = l; if2.right = r; if2.hazard = h; if2.brake = b; end
            default: begin if3.left = l; if3.right = r; if3.hazard = h; if3.brake = b; end
        endcase
        mdl_step(k, l, r, h, b);
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tl%0d", k), got_tl[k], ex_tl[k]);
            chk($sformatf("busy%0d", k), 16'(got_bz[k]), 16'(ex_bz[k]));
        end
    endtask

    logic [15:0] hold_left_seq [4] = '{16'h08, 16'h18, 16'h38, 16'h00};

    initial begin
        for (int k = 0; k < 4; k++) begin
            mdl_reset(k);
            case (k)
                0: begin if0.left = 0; if0.right = 0; if0.hazard = 0; if0.brake = 0; end
                1: begin if1.left = 0; if1.right = 0; if1.hazard = 0; if1.brake = 0; end
                2: begin if2.left = 0; if2.right = 0; if2.hazard = 0; if2.brake = 0; end
                default: begin if3.left = 0; if3.right = 0; if3.hazard = 0; if3.brake = 0; end
            endcase
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_tl%0d", k), got_tl[k], 16'h0);
            chk($sformatf("rst_busy%0d", k), 16'(got_bz[k]), 16'h0);
        end
        reset = 1'b0;

        // Hold left from the first edge after reset
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) apply(k, 1, 0, 0, 0);
            @(negedge clk);
            check_all();
            chk("hold_left", got_tl[0], hold_left_seq[c % 4]);
            chk("hold_busy", 16'(got_bz[0]), 16'((c % 4) != 3));
        end

        // Randomised traffic; hazard rare so sequences usually complete
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++)
                apply(k, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                         $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
            @(negedge clk);
            check_all();
        end

        // Quiet, then start a left sweep and reset asynchronously mid-sequence
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 4; k++) apply(k, 0, 0, 0, 0);
            @(negedge clk);
        end
        check_all();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) apply(k, 1, 0, 0, 0);
            @(negedge clk);
            check_all();
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("async_tl%0d", k), got_tl[k], 16'h0);
            chk($sformatf("async_busy%0d", k), 16'(got_bz[k]), 16'h0);
            mdl_reset(k);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) apply(k, 0, 1, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_all();
        chk("rel_right", got_tl[2], 16'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
